// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Function : registered MIPS-32 instruction decoder with an output + skid buffer
// Revision : 1.0  initial release
// ============================================================================
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      Instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       OpCode,
    output logic [4:0]       Rs,
    output logic [4:0]       Rt,
    output logic [4:0]       Rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [XLEN-1:0]  immediate,
    output logic [25:0]      target,
    output logic [1:0]       iclass,
    output logic             illegal,
    output logic [CNT_W-1:0] decode_count
);

    localparam logic [1:0] C_CLS_R   = 2'b00;
    localparam logic [1:0] C_CLS_I   = 2'b01;
    localparam logic [1:0] C_CLS_J   = 2'b10;
    localparam logic [1:0] C_CLS_ILL = 2'b11;

    if (XLEN < 16) begin : g_xlen_check
        $error("decode_stage: XLEN must be at least 16");
    end

    typedef struct packed {
        logic [5:0]      opcode;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [5:0]      funct;
        logic [XLEN-1:0] imm;
        logic [25:0]     target;
        logic [1:0]      iclass;
    } dec_t;

    logic [5:0]       w_op;
    logic [1:0]       w_cls;
    dec_t             w_dec;
    logic             w_acc;
    logic             w_cons;

    dec_t             out_q,        out_d;
    dec_t             skid_q,       skid_d;
    logic             out_valid_q,  out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q,   in_ready_d;
    logic [CNT_W-1:0] count_q,      count_d;

    assign w_op = Instruction[31:26];

    always_comb begin
        w_cls = C_CLS_ILL;
        case (w_op)
            6'd0:                           w_cls = C_CLS_R;
            6'd2, 6'd3:                     w_cls = C_CLS_J;
            6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15,
            6'd32, 6'd35, 6'd40, 6'd43:     w_cls = C_CLS_I;
            default:                        w_cls = C_CLS_ILL;
        endcase
    end

    // Fields that do not belong to the class are forced to zero before storage.
    always_comb begin
        w_dec        = '0;
        w_dec.opcode = w_op;
        w_dec.iclass = w_cls;
        case (w_cls)
            C_CLS_R: begin
                w_dec.rs    = Instruction[25:21];
                w_dec.rt    = Instruction[20:16];
                w_dec.rd    = Instruction[15:11];
                w_dec.shamt = Instruction[10:6];
                w_dec.funct = Instruction[5:0];
            end
            C_CLS_I: begin
                w_dec.rs = Instruction[25:21];
                w_dec.rt = Instruction[20:16];
                if (w_op == 6'd12 || w_op == 6'd13 || w_op == 6'd14) begin
                    w_dec.imm = XLEN'(Instruction[15:0]);
                end else begin
                    w_dec.imm = XLEN'($signed(Instruction[15:0]));
                end
            end
            C_CLS_J: begin
                w_dec.target = Instruction[25:0];
            end
            default: begin
                w_dec.opcode = w_op;
            end
        endcase
    end

    assign w_acc  = in_valid & in_ready_q & ~flush;
    assign w_cons = out_valid_q & out_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low whenever the skid is occupied, so only draining can happen.
            if (w_cons) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (w_acc) begin
            if (!out_valid_q || w_cons) begin
                out_d       = w_dec;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = w_dec;
                skid_valid_d = 1'b1;
            end
        end else if (w_cons) begin
            out_valid_d = 1'b0;
        end
    end

    assign in_ready_d = ~skid_valid_d;
    assign count_d    = count_q + CNT_W'(w_cons);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            count_q      <= '0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            count_q      <= count_d;
        end
    end

    assign in_ready     = in_ready_q & ~flush;
    assign out_valid    = out_valid_q;
    assign OpCode       = out_q.opcode;
    assign Rs           = out_q.rs;
    assign Rt           = out_q.rt;
    assign Rd           = out_q.rd;
    assign shamt        = out_q.shamt;
    assign funct        = out_q.funct;
    assign immediate    = out_q.imm;
    assign target       = out_q.target;
    assign iclass       = out_q.iclass;
    assign illegal      = (out_q.iclass == C_CLS_ILL);
    assign decode_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// Bench for decode_stage: queue-based reference model compared every cycle,
// plus directed words with hand-computed literal expectations.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] Instruction = 32'h0;

    logic        in_ready, out_valid, illegal;
    logic [5:0]  OpCode, funct;
    logic [4:0]  Rs, Rt, Rd, shamt;
    logic [31:0] immediate;
    logic [25:0] target;
    logic [1:0]  iclass;
    logic [15:0] decode_count;

    logic        in_ready_w, out_valid_w, illegal_w;
    logic [5:0]  OpCode_w, funct_w;
    logic [4:0]  Rs_w, Rt_w, Rd_w, shamt_w;
    logic [31:0] immediate_w;
    logic [25:0] target_w;
    logic [1:0]  iclass_w;
    logic [1:0]  decode_count_w;

    decode_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .Instruction(Instruction), .out_valid(out_valid), .out_ready(out_ready),
        .OpCode(OpCode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .shamt(shamt), .funct(funct),
        .immediate(immediate), .target(target), .iclass(iclass), .illegal(illegal),
        .decode_count(decode_count)
    );

    decode_stage #(.XLEN(32), .CNT_W(2)) dut_w (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w),
        .Instruction(Instruction), .out_valid(out_valid_w), .out_ready(out_ready),
        .OpCode(OpCode_w), .Rs(Rs_w), .Rt(Rt_w), .Rd(Rd_w), .shamt(shamt_w), .funct(funct_w),
        .immediate(immediate_w), .target(target_w), .iclass(iclass_w), .illegal(illegal_w),
        .decode_count(decode_count_w)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [31:0] imm;
        logic [25:0] tgt;
        logic [1:0]  cls;
    } exp_t;

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t       e;
        logic [5:0] op;
        op    = w[31:26];
        e     = '0;
        e.op  = op;
        if (op == 6'd0)                      e.cls = 2'b00;
        else if (op == 6'd2 || op == 6'd3)   e.cls = 2'b10;
        else if (op inside {6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14,
                            6'd15, 6'd32, 6'd35, 6'd40, 6'd43})
                                             e.cls = 2'b01;
        else                                 e.cls = 2'b11;
        if (e.cls == 2'b00) begin
            e.rs = w[25:21]; e.rt = w[20:16]; e.rd = w[15:11]; e.sh = w[10:6]; e.fn = w[5:0];
        end else if (e.cls == 2'b01) begin
            e.rs  = w[25:21];
            e.rt  = w[20:16];
            e.imm = (op inside {6'd12, 6'd13, 6'd14}) ? {16'h0000, w[15:0]} : {{16{w[15]}}, w[15:0]};
        end else if (e.cls == 2'b10) begin
            e.tgt = w[25:0];
        end
        return e;
    endfunction

    // Reference: FIFO of at most two accepted words; the head is what the output shows.
    logic [31:0] mq[$];
    int unsigned m_cnt  = 0;
    logic [31:0] m_last = 32'h0;

    always @(posedge clk or negedge reset_n) begin
        bit acc, cons;
        if (!reset_n) begin
            mq.delete();
            m_cnt  = 0;
            m_last = 32'h0;
        end else begin
            acc  = in_valid && (mq.size() < 2) && !flush;
            cons = (mq.size() > 0) && out_ready;
            if (cons) begin
                m_cnt++;
                void'(mq.pop_front());
            end
            if (flush) mq.delete();
            else if (acc) mq.push_back(Instruction);
            if (mq.size() > 0) m_last = mq[0];
        end
    end

    always @(negedge clk) begin
        exp_t e;
        e = ref_decode(m_last);
        chk("m_out_valid",   32'(out_valid),      32'(mq.size() > 0));
        chk("m_in_ready",    32'(in_ready),       32'((mq.size() < 2) && !flush));
        chk("m_opcode",      32'(OpCode),         32'(e.op));
        chk("m_rs",          32'(Rs),             32'(e.rs));
        chk("m_rt",          32'(Rt),             32'(e.rt));
        chk("m_rd",          32'(Rd),             32'(e.rd));
        chk("m_shamt",       32'(shamt),          32'(e.sh));
        chk("m_funct",       32'(funct),          32'(e.fn));
        chk("m_immediate",   immediate,           e.imm);
        chk("m_target",      32'(target),         32'(e.tgt));
        chk("m_iclass",      32'(iclass),         32'(e.cls));
        chk("m_illegal",     32'(illegal),        32'(e.cls == 2'b11));
        chk("m_count",       32'(decode_count),   32'(m_cnt % 65536));
        chk("m_count_w",     32'(decode_count_w), 32'(m_cnt % 4));
        chk("m_out_valid_w", 32'(out_valid_w),    32'(mq.size() > 0));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    localparam logic [31:0] W1 = 32'h00221905;
    localparam logic [31:0] W2 = 32'h8C220003;
    localparam logic [31:0] W3 = 32'h2022FFFF;

    initial begin
        repeat (3) step();
        reset_n = 1'b1;
        step();
        chk("rst_out_valid", 32'(out_valid),    32'd0);
        chk("rst_in_ready",  32'(in_ready),     32'd1);
        chk("rst_count",     32'(decode_count), 32'd0);
        chk("rst_rd",        32'(Rd),           32'd0);

        // R-type
        out_ready = 1'b1; in_valid = 1'b1; Instruction = W1;
        step();
        in_valid = 1'b0;
        chk("r_valid", 32'(out_valid), 32'd1);
        chk("r_op",    32'(OpCode),    32'd0);
        chk("r_rs",    32'(Rs),        32'd1);
        chk("r_rt",    32'(Rt),        32'd2);
        chk("r_rd",    32'(Rd),        32'd3);
        chk("r_shamt", 32'(shamt),     32'd4);
        chk("r_funct", 32'(funct),     32'd5);
        chk("r_imm",   immediate,      32'd0);
        chk("r_tgt",   32'(target),    32'd0);
        chk("r_cls",   32'(iclass),    32'd0);
        step();
        chk("r_drain", 32'(out_valid), 32'd0);

        // I, J and illegal words streamed back to back
        in_valid = 1'b1; Instruction = W2;
        step();
        chk("lw_op",  32'(OpCode),    32'd35);
        chk("lw_rs",  32'(Rs),        32'd1);
        chk("lw_rt",  32'(Rt),        32'd2);
        chk("lw_imm", immediate,      32'd3);
        chk("lw_fn",  32'(funct),     32'd0);
        chk("lw_tgt", 32'(target),    32'd0);
        chk("lw_cls", 32'(iclass),    32'd1);
        Instruction = W3;
        step();
        chk("addi_imm", immediate,    32'hFFFFFFFF);
        chk("addi_rd",  32'(Rd),      32'd0);
        chk("addi_fn",  32'(funct),   32'd0);
        Instruction = 32'h3422FFFF;
        step();
        chk("ori_imm",  immediate,    32'h0000FFFF);
        Instruction = 32'h08000003;
        step();
        chk("j_op",  32'(OpCode), 32'd2);
        chk("j_tgt", 32'(target), 32'd3);
        chk("j_fn",  32'(funct),  32'd0);
        chk("j_imm", immediate,   32'd0);
        chk("j_cls", 32'(iclass), 32'd2);
        Instruction = 32'hFC000000;
        step();
        chk("ill_op",  32'(OpCode),  32'd63);
        chk("ill_cls", 32'(iclass),  32'd3);
        chk("ill_flg", 32'(illegal), 32'd1);
        chk("ill_tgt", 32'(target),  32'd0);
        in_valid = 1'b0;
        step();
        chk("stream_count", 32'(decode_count), 32'd6);

        // Every opcode with two different bodies (bit 15 set and clear)
        in_valid = 1'b1;
        for (int i = 0; i < 128; i++) begin
            Instruction = {6'(i >> 1), (i % 2 == 1) ? 26'h3F08F0F : 26'h0A57C3A};
            step();
        end
        in_valid = 1'b0;
        step();
        chk("sweep_count", 32'(decode_count), 32'd134);

        // Backpressure
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; Instruction = W1;
        step();
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        chk("bp_fn1",  32'(funct),    32'd5);
        Instruction = W2;
        step();
        chk("bp_rdy2", 32'(in_ready), 32'd0);
        chk("bp_fn2",  32'(funct),    32'd5);
        Instruction = W3;
        step();
        chk("bp_rdy3", 32'(in_ready),     32'd0);
        chk("bp_rd3",  32'(Rd),           32'd3);
        chk("bp_cnt0", 32'(decode_count), 32'd0);
        out_ready = 1'b1;
        step();
        chk("bp_op2",  32'(OpCode),       32'd35);
        chk("bp_cnt1", 32'(decode_count), 32'd1);
        chk("bp_rdy4", 32'(in_ready),     32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_op3",  32'(OpCode),       32'd8);
        chk("bp_cnt2", 32'(decode_count), 32'd2);
        step();
        chk("bp_empty", 32'(out_valid),    32'd0);
        chk("bp_cnt3",  32'(decode_count), 32'd3);

        // Flush with both entries full
        out_ready = 1'b0; in_valid = 1'b1; Instruction = W1;
        step();
        Instruction = W2;
        step();
        chk("fl_full", 32'(in_ready), 32'd0);
        flush = 1'b1; Instruction = W3;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid1", 32'(out_valid),    32'd0);
        chk("fl_cnt1",   32'(decode_count), 32'd3);
        step();
        chk("fl_valid2", 32'(out_valid),    32'd0);
        chk("fl_rdy2",   32'(in_ready),     32'd1);
        chk("fl_cnt2",   32'(decode_count), 32'd3);

        // Flush in a cycle that also transfers out and offers a word
        in_valid = 1'b1; Instruction = W2;
        step();
        chk("flx_op", 32'(OpCode), 32'd35);
        flush = 1'b1; out_ready = 1'b1; Instruction = W3;
        #1;
        chk("flx_rdy", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        chk("flx_valid", 32'(out_valid),    32'd0);
        chk("flx_cnt",   32'(decode_count), 32'd4);

        // Patterned traffic mixing stalls and occasional flushes
        for (int i = 0; i < 300; i++) begin
            in_valid    = ((i * 7) % 5) != 0;
            out_ready   = ((i * 3) % 7) < 4;
            flush       = (i % 41) == 40;
            Instruction = 32'(i) * 32'h9E3779B9;
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        // Counter wrap on the 2-bit instance
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            Instruction = W1 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("wrap_cnt_w", 32'(decode_count_w), 32'd1);
        chk("wrap_cnt",   32'(decode_count),   32'd5);

        // Asynchronous reset between edges with both entries full
        out_ready = 1'b0; in_valid = 1'b1; Instruction = W1;
        step();
        Instruction = W2;
        step();
        in_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #2;
        chk("ar_valid", 32'(out_valid),    32'd0);
        chk("ar_rd",    32'(Rd),           32'd0);
        chk("ar_fn",    32'(funct),        32'd0);
        chk("ar_cnt",   32'(decode_count), 32'd0);
        #1;
        reset_n = 1'b1;
        step();
        in_valid = 1'b1; out_ready = 1'b1; Instruction = W2;
        step();
        in_valid = 1'b0;
        chk("ar_post_valid", 32'(out_valid), 32'd1);
        chk("ar_post_op",    32'(OpCode),    32'd35);
        chk("ar_post_imm",   immediate,      32'd3);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered MIPS-32 instruction decode stage with valid/ready handshakes on both sides and a 2-entry (output + skid) buffer.
- Splits each instruction into opcode/rs/rt/rd/shamt/funct/immediate/target and classifies it as R, I, J or illegal.
- Gates the fields that do not apply to the class, and extends the immediate to a parametrised width.
- Sits between instruction fetch and register read in the multicycle/pipelined datapath; replaces the purely combinational decoder.

Parameters:
- XLEN, 32, width of extended immediate output; legal range ≥16.
- CNT_W, 16, width of the retired-decode counter.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous; empties the buffer
- in_valid  input  1  instruction offered
- in_ready  output  1  stage can accept
- Instruction  input  32  raw instruction word
- out_valid  output  1  decoded word present
- out_ready  input  1  consumer accepts
- OpCode  output  6  bits [31:26]
- Rs  output  5  bits [25:21], class-gated
- Rt  output  5  bits [20:16], class-gated
- Rd  output  5  bits [15:11], class-gated
- shamt  output  5  bits [10:6], class-gated
- funct  output  6  bits [5:0], class-gated
- immediate  output  XLEN  extended bits [15:0], class-gated
- target  output  26  bits [25:0], class-gated
- iclass  output  2  00=R, 01=I, 10=J, 11=illegal
- illegal  output  1  equals iclass==11
- decode_count  output  CNT_W  number of output handshakes

Behaviour:
- Reset (reset_n low, asynchronous): out_valid=0, skid empty, in_ready=1 after release. All field outputs, iclass, illegal and decode_count are 0.
- Classification is combinational on Instruction at input acceptance; results are stored in the buffer entries.
  - OpCode 0 → R.
  - OpCode 2, 3 → J.
  - OpCode 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 32, 35, 40, 43 → I.
  - Any other opcode → illegal.
- Field gating:
  - R: Rs, Rt, Rd, shamt, funct pass; immediate=0, target=0.
  - I: Rs, Rt, immediate pass; Rd=shamt=funct=0, target=0.
  - J: target passes; Rs=Rt=Rd=shamt=funct=0, immediate=0.
  - Illegal: every field 0 except OpCode, which always passes.
- Immediate extension: zero-extend for OpCode 12, 13, 14 (andi/ori/xori); sign-extend bit 15 to XLEN for all other I-type opcodes.
- Handshakes:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - in_ready = !skid_full & !flush, registered (no combinational path from out_ready).
- Latency: accepted word appears on the outputs the next cycle (out_valid=1). Throughput is 1 word/cycle while out_ready stays high.
- Buffering:
  - If the output is occupied and not consumed while a new word is accepted, the new word goes to skid; in_ready drops the following cycle.
  - On the next output transfer, skid moves to output, and in_ready rises the following cycle.
  - Order is strictly preserved.
- Output stability: while out_valid=1 & out_ready=0, all decoded outputs hold constant.
- Full boundary: with both entries full, in_ready=0; in_valid is ignored.
- Empty boundary: out_valid=0; outputs hold their last values (not required to be zero).
- Simultaneous accept and consume with the output full and the skid empty: the new word replaces the output; skid stays empty.
- Flush:
  - Next edge: out_valid=0, skid empty.
  - A word presented in the flush cycle is dropped, since in_ready=0.
  - An output transfer in the flush cycle still counts.
  - decode_count is not cleared.
- decode_count: +1 on every output transfer, wraps modulo 2^CNT_W.
- Reset mid-operation: immediate return to reset values; buffered words are lost.

Test Plan:
- R-type:
  - Stimulus: Instruction=0x00221905, out_ready=1.
  - Response: one cycle later out_valid=1, OpCode=0, Rs=1, Rt=2, Rd=3, shamt=4, funct=5, immediate=0, target=0, iclass=00.
- I-type:
  - Stimulus: lw 0x8C220003, then addi 0x2022FFFF, then ori 0x3422FFFF.
  - Response:
    - lw: OpCode=35, Rs=1, Rt=2, immediate=3, Rd=shamt=funct=0, target=0.
    - addi: immediate=0xFFFFFFFF.
    - ori: immediate=0x0000FFFF (XLEN=32).
- J-type and illegal:
  - Stimulus: 0x08000003, then 0xFC000000.
  - Response:
    - J word: OpCode=2, target=3, other fields 0, iclass=10.
    - Illegal word: OpCode=63, iclass=11, illegal=1, all other fields 0.
- Backpressure:
  - Stimulus: hold out_ready=0, stream 3 words.
  - Response: words 1 and 2 are accepted and in_ready=0 from the cycle after word 2; outputs stay on word 1.
  - Then release out_ready: words emerge 1, 2, 3 in order; decode_count goes 0→3.
- Flush and counter wrap:
  - Stimulus A: both entries full, assert flush for 1 cycle.
  - Response A: out_valid=0 and in_ready=1 two cycles later; decode_count unchanged.
  - Stimulus B: CNT_W=2, complete 5 transfers.
  - Response B: decode_count=1.
- Async reset:
  - Stimulus: drop reset_n mid-stream, between clock edges.
  - Response: out_valid=0, all outputs 0 immediately; after release the next accepted word decodes normally.
